// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion,
// flush/stall handling and a saturating bubble counter.
module id_ex_pipe #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [9:0]       id_ctrl,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [DW-1:0]    id_rdata1,
  input  logic [DW-1:0]    id_rdata2,
  input  logic [DW-1:0]    id_imm,
  input  logic [DW-1:0]    id_pc4,
  output logic [9:0]       ex_ctrl,
  output logic             ex_valid,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_rd,
  output logic [DW-1:0]    ex_rdata1,
  output logic [DW-1:0]    ex_rdata2,
  output logic [DW-1:0]    ex_imm,
  output logic [DW-1:0]    ex_pc4,
  output logic             hazard_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  localparam int MEMREAD = 5;

  logic [9:0]       r_ctrl;
  logic             r_valid;
  logic [4:0]       r_rs;
  logic [4:0]       r_rt;
  logic [4:0]       r_rd;
  logic [DW-1:0]    r_rdata1;
  logic [DW-1:0]    r_rdata2;
  logic [DW-1:0]    r_imm;
  logic [DW-1:0]    r_pc4;
  logic [CNT_W-1:0] r_cnt;

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_load_use;
  logic w_bubble;
  logic w_cnt_max;

  // $0 can never carry a pending load result
  assign w_rs_hit   = id_uses_rs & (id_rs == r_rt);
  assign w_rt_hit   = id_uses_rt & (id_rt == r_rt);
  assign w_load_use = r_valid & r_ctrl[MEMREAD]
                    & (r_rt != 5'd0) & id_valid
                    & (w_rs_hit | w_rt_hit);
  assign w_bubble   = flush_i | w_load_use;
  assign w_cnt_max  = &r_cnt;

  assign hazard_stall_o = w_load_use & ~flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl   <= '0;
      r_valid  <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
      r_cnt    <= '0;
    end else if (stall_i) begin
      r_ctrl   <= r_ctrl;
    end else if (w_bubble) begin
      r_ctrl   <= '0;
      r_valid  <= 1'b0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
      if (!flush_i && !w_cnt_max)
        r_cnt  <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_ctrl   <= id_valid ? id_ctrl : 10'd0;
      r_valid  <= id_valid;
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_rd     <= id_rd;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_pc4    <= id_pc4;
    end
  end

  assign ex_ctrl      = r_ctrl;
  assign ex_valid     = r_valid;
  assign ex_rs        = r_rs;
  assign ex_rt        = r_rt;
  assign ex_rd        = r_rd;
  assign ex_rdata1    = r_rdata1;
  assign ex_rdata2    = r_rdata2;
  assign ex_imm       = r_imm;
  assign ex_pc4       = r_pc4;
  assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe (CNT_W = 4 so saturation
// is reachable); expected outputs queued per edge.
module tb_id_ex_pipe;

  localparam int DW    = 32;
  localparam int CNT_W = 4;
  localparam logic [9:0] C_LW  = 10'b0001100110;
  localparam logic [9:0] C_ADD = 10'b0010000010;

  typedef struct packed {
    logic [9:0]       ctrl;
    logic             valid;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [DW-1:0]    d1;
    logic [DW-1:0]    d2;
    logic [DW-1:0]    imm;
    logic [DW-1:0]    pc4;
    logic [CNT_W-1:0] cnt;
  } st_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             stall_i;
  logic             flush_i;
  logic [9:0]       id_ctrl;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [DW-1:0]    id_rdata1;
  logic [DW-1:0]    id_rdata2;
  logic [DW-1:0]    id_imm;
  logic [DW-1:0]    id_pc4;
  logic [9:0]       ex_ctrl;
  logic             ex_valid;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic [4:0]       ex_rd;
  logic [DW-1:0]    ex_rdata1;
  logic [DW-1:0]    ex_rdata2;
  logic [DW-1:0]    ex_imm;
  logic [DW-1:0]    ex_pc4;
  logic             hazard_stall_o;
  logic [CNT_W-1:0] bubble_cnt_o;

  id_ex_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .id_ctrl(id_ctrl), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2),
    .id_imm(id_imm), .id_pc4(id_pc4),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
    .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .hazard_stall_o(hazard_stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk = ~clk;

  int  n_cmp = 0;
  int  n_err = 0;
  st_t m;
  st_t q[$];

  function automatic st_t obs();
    return '{ex_ctrl, ex_valid, ex_rs, ex_rt, ex_rd,
             ex_rdata1, ex_rdata2, ex_imm, ex_pc4,
             bubble_cnt_o};
  endfunction

  task automatic chk(string tag, logic [191:0] o,
                     logic [191:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic lu_exp();
    return m.valid && m.ctrl[5] && m.rt != 5'd0 && id_valid
      && ((id_uses_rs && id_rs == m.rt) ||
          (id_uses_rt && id_rt == m.rt));
  endfunction

  // one edge: check hazard, predict, push, clock, pop, compare
  task automatic cyc(string tag);
    logic lu;
    st_t  e;
    #1;
    lu = lu_exp();
    chk({tag, "/haz"}, 192'(hazard_stall_o),
        192'(lu && !flush_i));
    if (stall_i) begin
    end else if (flush_i || lu) begin
      m.ctrl = '0; m.valid = 1'b0;
      m.rs = '0; m.rt = '0; m.rd = '0;
      m.d1 = '0; m.d2 = '0; m.imm = '0; m.pc4 = '0;
      if (!flush_i && m.cnt != '1) m.cnt = m.cnt + 1'b1;
    end else begin
      m.ctrl = id_valid ? id_ctrl : 10'd0;
      m.valid = id_valid;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.d1 = id_rdata1; m.d2 = id_rdata2;
      m.imm = id_imm; m.pc4 = id_pc4;
    end
    q.push_back(m);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, "/queue"}, 192'(0), 192'(1));
    end else begin
      e = q.pop_front();
      chk({tag, "/ex"}, 192'(obs()), 192'(e));
    end
  endtask

  task automatic drv(logic [9:0] c, logic v, logic [4:0] rs,
                     logic [4:0] rt, logic urs, logic urt);
    id_ctrl = c; id_valid = v;
    id_rs = rs; id_rt = rt; id_rd = 5'($urandom);
    id_uses_rs = urs; id_uses_rt = urt;
    id_rdata1 = $urandom; id_rdata2 = $urandom;
    id_imm = $urandom; id_pc4 = $urandom;
  endtask

  initial begin
    m = '0;
    rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    drv(C_ADD, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset/ex", 192'(obs()), 192'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cyc("first");
    chk("first/ctrl", 192'(ex_ctrl), 192'(C_ADD));

    // load-use on rs
    drv(C_LW, 1'b1, 5'd9, 5'd8, 1'b1, 1'b0);
    cyc("lw8");
    drv(C_ADD, 1'b1, 5'd8, 5'd10, 1'b1, 1'b1);
    #1 chk("lu/haz1", 192'(hazard_stall_o), 192'(1));
    cyc("lu/bubble");
    chk("lu/cnt", 192'(bubble_cnt_o), 192'(1));
    chk("lu/valid", 192'(ex_valid), 192'(0));
    cyc("lu/add");
    chk("lu/addctrl", 192'(ex_ctrl), 192'(C_ADD));

    // no false hazards
    drv(C_LW, 1'b1, 5'd4, 5'd0, 1'b1, 1'b0);
    cyc("lw0");
    drv(C_ADD, 1'b1, 5'd0, 5'd6, 1'b1, 1'b1);
    cyc("r0");
    drv(C_LW, 1'b1, 5'd4, 5'd8, 1'b1, 1'b0);
    cyc("lw8b");
    drv(C_ADD, 1'b1, 5'd3, 5'd8, 1'b1, 1'b0);
    cyc("nouse");
    drv(C_LW, 1'b1, 5'd4, 5'd8, 1'b1, 1'b0);
    cyc("lw8c");
    drv(C_ADD, 1'b0, 5'd8, 5'd8, 1'b1, 1'b1);
    cyc("invalid");
    chk("invalid/ctrl", 192'(ex_ctrl), 192'(0));

    // flush beats load-use
    drv(C_LW, 1'b1, 5'd4, 5'd8, 1'b1, 1'b0);
    cyc("lw8d");
    drv(C_ADD, 1'b1, 5'd8, 5'd7, 1'b1, 1'b1);
    flush_i = 1'b1;
    cyc("flush");
    flush_i = 1'b0;
    chk("flush/cnt", 192'(bubble_cnt_o), 192'(1));

    // memory stall holds, ignores flush
    drv(C_ADD, 1'b1, 5'd11, 5'd12, 1'b1, 1'b1);
    cyc("prestall");
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drv(10'($urandom), 1'b1, 5'($urandom), 5'($urandom),
          1'b1, 1'b1);
      flush_i = (i == 1);
      cyc("stall");
    end
    stall_i = 1'b0; flush_i = 1'b0;
    cyc("resume");

    // hazard during stall, then saturation
    drv(C_LW, 1'b1, 5'd4, 5'd5, 1'b1, 1'b0);
    cyc("lw5");
    drv(C_ADD, 1'b1, 5'd5, 5'd1, 1'b1, 1'b1);
    stall_i = 1'b1;
    cyc("stallhaz");
    stall_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drv(C_LW, 1'b1, 5'd4, 5'd5, 1'b1, 1'b0);
      cyc("sat/lw");
      drv(C_ADD, 1'b1, 5'd1, 5'd5, 1'b0, 1'b1);
      cyc("sat/bub");
    end
    chk("sat/cnt", 192'(bubble_cnt_o), 192'(4'hF));

    // async reset mid-cycle while stalled
    drv(C_LW, 1'b1, 5'd4, 5'd9, 1'b1, 1'b0);
    cyc("prerst");
    stall_i = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("arst/ex", 192'(obs()), 192'(0));
    m = '0;
    stall_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv(C_ADD, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1);
    cyc("postrst");
    chk("postrst/valid", 192'(ex_valid), 192'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the 5-stage MIPS core.
- Sits directly downstream of the instruction decoder. Captures the decoder's 10-bit control word plus operand data at each clock edge and presents them to the EX stage.
- Detects load-use hazards against the instruction in EX, inserts a bubble, and requests a front-end stall.
- Handles flushes (taken branch, jump) and global memory stalls, and keeps a saturating bubble counter for performance analysis.

Parameters:
- DW, 32, datapath width of register data, immediate and PC+4.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- stall_i  in  1  global memory stall; freezes this register.
- flush_i  in  1  kill the instruction currently in ID (taken branch, jump, jr).
- id_ctrl  in  10  decoder output {Jump,Jr,RegDst,ALUsrc,MemRead,MemWrite,Branch,MemtoReg,RegWrite,Jal}; bit 5 = MemRead.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt, id_rd  in  5 each  register indices.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
- id_rdata1, id_rdata2  in  DW each  register-file read data.
- id_imm  in  DW  sign/zero-extended immediate.
- id_pc4  in  DW  PC+4 of the ID instruction.
- ex_ctrl  out  10  registered control word.
- ex_valid  out  1  EX holds a real instruction.
- ex_rs, ex_rt, ex_rd  out  5 each  registered indices.
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DW each  registered data.
- hazard_stall_o  out  1  combinational; holds PC and IF/ID when high.
- bubble_cnt_o  out  CNT_W  count of bubbles inserted by load-use detection.

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, ex_valid is 0, bubble_cnt_o is 0. Reset asserted mid-stall or mid-bubble discards all state.
- Load-use detect (combinational):
  - load_use = ex_valid & ex_ctrl[5] & (ex_rt != 0) & id_valid & ((id_uses_rs & id_rs == ex_rt) | (id_uses_rt & id_rt == ex_rt)).
  - hazard_stall_o = load_use & ~flush_i.
- Per-edge update, in priority order:
  1. stall_i = 1: HOLD. All registers keep their value; counter unchanged. Takes priority over flush_i and load_use.
  2. flush_i = 1: BUBBLE. ex_ctrl = 0, ex_valid = 0, data fields don't-care (implementation clears them to 0). Counter unchanged.
  3. load_use = 1: BUBBLE as above. bubble_cnt_o increments by 1 and saturates at all-ones (no wrap).
  4. Otherwise CAPTURE: all id_* fields are registered. ex_valid = id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
- Latency: one cycle from ID inputs to ex_* outputs.
- A load-use stall lasts exactly one cycle: after the bubble, ex_valid = 0, so load_use falls.
- $0 is never a hazard source.
- While stall_i is high, hazard_stall_o may be asserted; it is harmless because the front end is frozen anyway.
- An invalid ID slot (id_valid = 0) never raises hazard_stall_o.

Test Plan:
- Reset: drive rst_n low mid-cycle with ex_ctrl nonzero -> all outputs 0 immediately, without waiting for a clock edge. Release -> first edge captures id_ctrl = 10'b0010000010, ex_valid = 1.
- Load-use: EX holds lw $8 (ex_ctrl = 10'b0001100110, ex_rt = 8); ID add with id_rs = 8, id_uses_rs = 1 -> hazard_stall_o = 1 for one cycle, next ex_ctrl = 0, ex_valid = 0, bubble_cnt_o = 1. The following edge captures the add.
- No false hazard: lw to $0 with ID rs = 0 -> hazard_stall_o = 0. lw $8 with ID rt = 8 but id_uses_rt = 0 -> no stall.
- Flush vs load-use: flush_i = 1 together with a load_use condition -> hazard_stall_o = 0, bubble inserted, bubble_cnt_o unchanged.
- Memory stall: stall_i = 1 for 3 cycles with changing id_* inputs -> ex_* constant at pre-stall values. A flush asserted during the stall is ignored; capture resumes when stall_i drops.
- Saturation: CNT_W = 4; force 17 load-use bubbles -> bubble_cnt_o = 4'hF, no wrap.
